ps2_host_tx_ctrl: RTL and testbench

PS2_HOST_TX_CTRL -- requirements
Module: ps2_host_tx_ctrl

---
 rtl/ps2_host_tx_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_ps2_host_tx_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx_ctrl.sv
// PS/2 host-to-device command transmitter: clock inhibit, request-to-send, 11-bit
// frame clocked by the device, ack check and 0xFA/0xFE response handling with resends.
module ps2_host_tx_ctrl #(
  parameter int INHIBIT_CYC = 10000,
  parameter int TIMEOUT_CYC = 2000000,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_byte,
  output logic       cmd_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic       rx_en,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int INH_W = $clog2(INHIBIT_CYC + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 2);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYC - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  localparam logic [1:0] CODE_OK      = 2'b00;
  localparam logic [1:0] CODE_TIMEOUT = 2'b01;
  localparam logic [1:0] CODE_NACK    = 2'b10;
  localparam logic [1:0] CODE_RETRY   = 2'b11;

  typedef enum logic [2:0] {IDLE, INHIBIT, START, SEND, ACK, RESP, FIN} state_t;
  state_t state, state_next;

  logic [2:0]       clk_sync;   // [1:0] synchroniser, [2] previous synced level
  logic [1:0]       data_sync;
  logic             fe;
  logic [INH_W-1:0] inh_cnt;
  logic [WD_W-1:0]  wd_cnt;
  logic             wd_hit;
  logic [3:0]       bit_cnt;
  logic [RTY_W-1:0] retry_cnt;
  logic [7:0]       tx_byte;
  logic             data_drive;
  logic             ack_bit;
  logic             fail;
  logic             accept;
  logic             resend;
  logic             set_fail;
  logic [1:0]       fail_code;

  assign fe     = clk_sync[2] & ~clk_sync[1];
  assign wd_hit = (wd_cnt == WD_LAST);

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every signal written here gets a default first, so no path infers a latch.
  always_comb begin
    state_next  = state;
    cmd_ready   = 1'b0;
    busy        = 1'b1;
    rx_en       = 1'b1;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    accept      = 1'b0;
    resend      = 1'b0;
    set_fail    = 1'b0;
    fail_code   = CODE_OK;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          accept     = 1'b1;
          state_next = INHIBIT;
        end
      end
      INHIBIT: begin
        rx_en      = 1'b0;
        ps2_clk_oe = 1'b1;
        if (inh_cnt == INH_LAST) state_next = START;
      end
      START: begin
        rx_en       = 1'b0;
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = 1'b1;
        if (wd_hit) begin
          set_fail   = 1'b1;
          fail_code  = CODE_TIMEOUT;
          state_next = FIN;
        end else begin
          state_next = SEND;
        end
      end
      SEND: begin
        rx_en       = 1'b0;
        ps2_data_oe = data_drive;
        if (fe && bit_cnt == 4'd10) begin
          state_next = ACK;
        end else if (wd_hit) begin
          set_fail   = 1'b1;
          fail_code  = CODE_TIMEOUT;
          state_next = FIN;
        end
      end
      ACK: begin
        if (ack_bit) begin
          set_fail   = 1'b1;
          fail_code  = CODE_NACK;
          state_next = FIN;
        end else begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (rx_valid && rx_byte == 8'hFA) begin
          state_next = FIN;
        end else if (rx_valid && rx_byte == 8'hFE) begin
          if (retry_cnt == RTY_MAX) begin
            set_fail   = 1'b1;
            fail_code  = CODE_RETRY;
            state_next = FIN;
          end else begin
            resend     = 1'b1;
            state_next = INHIBIT;
          end
        end else if (wd_hit) begin
          set_fail   = 1'b1;
          fail_code  = CODE_TIMEOUT;
          state_next = FIN;
        end
      end
      FIN: begin
        done       = ~fail;
        err        = fail;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Both lines idle high, so the synchronisers reset to 1 to avoid a false edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= 3'b111;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inh_cnt <= '0;
      wd_cnt  <= '0;
    end else begin
      inh_cnt <= (state == INHIBIT && state_next == INHIBIT) ? inh_cnt + INH_W'(1) : '0;
      if (state_next != state || fe) wd_cnt <= '0;
      else if (!wd_hit)              wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_byte    <= '0;
      retry_cnt  <= '0;
      bit_cnt    <= '0;
      data_drive <= 1'b0;
      ack_bit    <= 1'b1;
      fail       <= 1'b0;
      err_code   <= CODE_OK;
    end else begin
      if (accept) begin
        tx_byte   <= cmd_byte;
        retry_cnt <= '0;
        fail      <= 1'b0;
        err_code  <= CODE_OK;
      end
      if (resend) retry_cnt <= retry_cnt + RTY_W'(1);
      if (set_fail) begin
        fail     <= 1'b1;
        err_code <= fail_code;
      end
      if (state == START) begin
        bit_cnt    <= '0;
        data_drive <= 1'b1;           // start bit stays on the line until the first fe
      end else if (state == SEND && fe) begin
        bit_cnt <= bit_cnt + 4'd1;
        if (bit_cnt < 4'd8)       data_drive <= ~tx_byte[bit_cnt[2:0]];
        else if (bit_cnt == 4'd8) data_drive <= ^tx_byte;  // odd parity bit is ~^byte; oe is its inverse
        else                      data_drive <= 1'b0;
        if (bit_cnt == 4'd10) ack_bit <= data_sync[1];
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx_ctrl.sv
// Bench for ps2_host_tx_ctrl: a PS/2 device model clocks frames out of the host and
// answers through the rx strobe; table-driven transactions plus reset/timeout sequences.
module tb_ps2_host_tx_ctrl;

  localparam int INH  = 200;
  localparam int TMO  = 3000;
  localparam int MAXR = 3;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_byte = '0;
  logic       cmd_ready;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe;
  logic [7:0] rx_byte = '0;
  logic       rx_valid = 1'b0;
  logic       rx_en, busy, done, err;
  logic [1:0] err_code;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;

  // Open-drain lines: low if either side pulls down.
  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  always #5 clk = ~clk;

  ps2_host_tx_ctrl #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .cmd_ready(cmd_ready),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_en(rx_en),
    .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitors: pulse counts, ready-while-busy, inhibit run lengths.
  int done_cnt = 0;
  int err_cnt = 0;
  int rdy_busy_bad = 0;
  int inh_run = 0;
  int inh_len[$];

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (err === 1'b1) err_cnt++;
    if (cmd_ready === 1'b1 && busy === 1'b1) rdy_busy_bad++;
    if (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0) inh_run++;
    else if (inh_run > 0) begin
      inh_len.push_back(inh_run);
      inh_run = 0;
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic pulse_rx(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Device side of host-to-device transfer; n_edges < 11 stops early with clock held low.
  task automatic dev_xfer(input int n_edges, input bit ack_one, output logic [7:0] b,
                          output logic par, output logic stp, output bit seen, output int rxen_bad);
    int w;
    logic [9:0] sh;
    seen = 1'b0; rxen_bad = 0; b = '0; par = 1'b0; stp = 1'b0; sh = '0; w = 0;
    while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && w < INH + 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= INH + 100) return;
    seen = 1'b1;
    for (int k = 1; k <= n_edges; k++) begin
      if (k == 11) dev_data = ack_one;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      if (k == n_edges && n_edges < 11) return;
      if (k <= 10) begin
        sh[k-1] = ps2_data_in;
        if (rx_en !== 1'b0) rxen_bad++;
      end
      dev_clk = 1'b1;
    end
    dev_data = 1'b1;
    b = sh[7:0]; par = sh[8]; stp = sh[9];
  endtask

  typedef struct {
    logic [7:0] cmd;
    bit         ack_one;   // device leaves ack high
    int         n_fe;      // 0xFE answers before the final one
    logic [7:0] final_rx;
    bit         noise;     // unrelated byte before the final answer
    bit         hold;      // cmd_valid kept high with another byte while busy
    bit         early;     // stray 0xFA strobe during inhibit
    int         exp_tx;
    logic       exp_par;
    int         exp_done;
    int         exp_err;
    logic [1:0] exp_code;
  } vec_t;

  task automatic run_txn(input vec_t v, input string tag);
    int w, tx, rb;
    logic [7:0] b;
    logic p, s;
    bit seen;
    done_cnt = 0; err_cnt = 0; rdy_busy_bad = 0; inh_len.delete();
    w = 0;
    while (cmd_ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check({tag, " ready"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_byte  = v.cmd;
    @(negedge clk);
    if (v.hold) cmd_byte = 8'h55;
    else        cmd_valid = 1'b0;
    if (v.early) begin
      repeat (3) @(negedge clk);
      pulse_rx(8'hFA);
    end
    tx = 0;
    for (int a = 0; a <= v.n_fe; a++) begin
      dev_xfer(11, v.ack_one, b, p, s, seen, rb);
      cmd_valid = 1'b0;
      if (!seen) begin
        check($sformatf("%s request%0d", tag, a), 0, 1);
        break;
      end
      tx++;
      check($sformatf("%s byte%0d", tag, a), b, v.cmd);
      check($sformatf("%s parity%0d", tag, a), p, v.exp_par);
      check($sformatf("%s stop%0d", tag, a), s, 1);
      check($sformatf("%s rx_en_send%0d", tag, a), rb, 0);
      if (v.ack_one) break;
      repeat (10) @(negedge clk);
      if (v.noise && a == v.n_fe) begin
        pulse_rx(8'hAA);
        repeat (5) @(negedge clk);
      end
      pulse_rx(a < v.n_fe ? 8'hFE : v.final_rx);
    end
    w = 0;
    while (busy !== 1'b0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check({tag, " end_in_time"}, w < 200, 1);
    repeat (5) @(negedge clk);
    check({tag, " transmissions"}, tx, v.exp_tx);
    check({tag, " done_cycles"}, done_cnt, v.exp_done);
    check({tag, " err_cycles"}, err_cnt, v.exp_err);
    check({tag, " err_code"}, err_code, v.exp_code);
    check({tag, " idle_lines"}, {ps2_clk_oe, ps2_data_oe, busy, rx_en}, 4'b0001);
    check({tag, " ready_while_busy"}, rdy_busy_bad, 0);
    check({tag, " inhibit_count"}, inh_len.size(), v.exp_tx);
    foreach (inh_len[i]) check($sformatf("%s inhibit_len%0d", tag, i), inh_len[i], INH);
  endtask

  vec_t vecs[5];

  initial begin
    int t, rb;
    logic [7:0] b;
    logic p, s;
    bit seen;

    //        cmd    ack  fe final   noise hold early tx par done err code
    vecs[0] = '{8'hED, 0, 0, 8'hFA, 0, 0, 0, 1, 1'b1, 1, 0, 2'b00};
    vecs[1] = '{8'hFF, 0, 2, 8'hFA, 0, 1, 0, 3, 1'b1, 1, 0, 2'b00};
    vecs[2] = '{8'hF4, 0, 3, 8'hFE, 0, 0, 0, 4, 1'b0, 0, 1, 2'b11};
    vecs[3] = '{8'h00, 1, 0, 8'h00, 0, 0, 0, 1, 1'b1, 0, 1, 2'b10};
    vecs[4] = '{8'h01, 0, 0, 8'hFA, 1, 0, 1, 1, 1'b0, 1, 0, 2'b00};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset outputs", {ps2_clk_oe, ps2_data_oe, busy, done, err, err_code, rx_en},
          8'b0000_0001);
    rst = 1'b0;
    @(negedge clk);
    check("ready after reset", cmd_ready, 1);

    for (int i = 0; i < 5; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Device never clocks: watchdog in SEND
    done_cnt = 0; err_cnt = 0;
    cmd_valid = 1'b1; cmd_byte = 8'hED;
    @(negedge clk);
    cmd_valid = 1'b0;
    t = 1;
    while (err !== 1'b1 && t < INH + TMO + 100) begin
      @(negedge clk);
      t++;
    end
    check("timeout err", err, 1);
    check("timeout latency", (t >= INH + TMO) && (t <= INH + TMO + 4), 1);
    check("timeout err_code", err_code, 2'b01);
    repeat (3) @(negedge clk);
    check("timeout lines released", {ps2_clk_oe, ps2_data_oe, busy}, 3'b000);
    check("timeout pulses", {done_cnt[7:0], err_cnt[7:0]}, 16'h0001);

    // Reset while bit 5 of 0x0F (a 0) is on the line
    done_cnt = 0; err_cnt = 0;
    cmd_valid = 1'b1; cmd_byte = 8'h0F;
    @(negedge clk);
    cmd_valid = 1'b0;
    dev_xfer(6, 1'b0, b, p, s, seen, rb);
    check("midrst request", seen, 1);
    check("midrst driving bit5", ps2_data_oe, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst released", {ps2_clk_oe, ps2_data_oe, busy}, 3'b000);
    rst = 1'b0;
    dev_clk = 1'b1;
    repeat (20) @(negedge clk);
    check("midrst no pulses", {done_cnt[7:0], err_cnt[7:0]}, 16'h0000);
    check("midrst err_code", err_code, 2'b00);
    run_txn(vecs[0], "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
